bus_transceiver: RTL and testbench

BUS_TRANSCEIVER -- requirements
Module: bus_transceiver

---
 rtl/bus_pkg.sv | 19 +
 rtl/tristate_buffer.sv | 12 +
 rtl/bus_transceiver.sv | 121 ++++++++++++
 tb/tb_bus_transceiver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the bus transceiver slice.
package bus_pkg;

  localparam int DEFAULT_N         = 8;
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TX_TA    = 2'd1,
    TX_DRIVE = 2'd2,
    TX_REL   = 2'd3
  } state_t;

  // States in which the bus is free for a remote talker to hand us a word.
  function automatic logic is_rx_state(input state_t s);
    return (s == IDLE) || (s == TX_REL);
  endfunction

endpackage

// File: rtl/tristate_buffer.sv
// Tristate driver: out follows a while en is high, otherwise floats.
module tristate_buffer #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         en,
  output tri   [W-1:0] out
);

  assign out = en ? a : {W{1'bz}};

endmodule

// File: rtl/bus_transceiver.sv
// Half-duplex shared-bus transceiver: arbitrated burst transmit with
// turnaround/release cycles, strobed receive and collision reporting.
module bus_transceiver
  import bus_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst,
  inout  tri   [N-1:0] bus,
  input  logic         strb_in,
  output logic         strb_out,
  input  logic         gnt,
  output logic         req,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         collision
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_BURST - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] burst_r;
  logic       oe_s;
  logic       req_s;
  logic       accept_s;

  // Next-state and handshake decode; a dropped grant blocks any further transfer.
  always_comb begin
    state_nxt_s = state_r;
    oe_s        = 1'b0;
    req_s       = 1'b0;
    tx_ready    = 1'b0;
    strb_out    = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        req_s = tx_valid;
        if (tx_valid && gnt && !strb_in) begin
          state_nxt_s = TX_TA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TX_TA: begin
        req_s       = 1'b1;
        state_nxt_s = gnt ? TX_DRIVE : IDLE;
      end
      TX_DRIVE: begin
        oe_s     = 1'b1;
        req_s    = 1'b1;
        tx_ready = gnt;
        strb_out = tx_valid && gnt;
        accept_s = tx_valid && gnt;
        if (!accept_s || (burst_r == LAST_IDX)) begin
          state_nxt_s = TX_REL;
        end else begin
          state_nxt_s = TX_DRIVE;
        end
      end
      TX_REL: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Reset overrides req immediately so a held tx_valid cannot leak through.
  assign req = req_s && !rst;

  // State register and per-tenure burst counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      burst_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r != TX_DRIVE) && (state_nxt_s == TX_DRIVE)) begin
        burst_r <= 8'd0;
      end else if (accept_s) begin
        burst_r <= burst_r + 8'd1;
      end else begin
        burst_r <= burst_r;
      end
    end
  end

  // Receive capture, or a collision flag when the remote strobes over our tenure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= {N{1'b0}};
      rx_valid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      collision <= 1'b0;
      if (strb_in) begin
        if (is_rx_state(state_r)) begin
          rx_data  <= bus;
          rx_valid <= 1'b1;
        end else begin
          collision <= 1'b1;
        end
      end
    end
  end

  tristate_buffer #(.W(N)) u_tristate_buffer (
    .a   (tx_data),
    .en  (oe_s),
    .out (bus)
  );

endmodule

// File: tb/tb_bus_transceiver.sv
// Directed self-checking bench for bus_transceiver (N=8, MAX_BURST=4).
module tb_bus_transceiver;

  logic       clk = 1'b0;
  logic       rst;
  tri   [7:0] bus;
  logic       strb_in, strb_out, gnt, req;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, collision;
  logic       drv_en;
  logic [7:0] drv_val;
  int         errors = 0;
  int         checks = 0;
  wire  [3:0] ctl = {dut.oe_s, req, tx_ready, strb_out};

  assign bus = drv_en ? drv_val : 8'bz;
  always #5 clk = ~clk;

  bus_transceiver #(.N(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .strb_in(strb_in), .strb_out(strb_out),
    .gnt(gnt), .req(req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .collision(collision)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({ctl, rx_valid, collision} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000000", {ctl, rx_valid, collision});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    tx_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_receive;
    drv_en = 1'b1; drv_val = 8'hA5; strb_in = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL receive_no_drive got %b want 0000", ctl);
    end
    tick();
    drv_en = 1'b0; strb_in = 1'b0;
    #1;
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL receive_word got %b/%h want 1/a5", rx_valid, rx_data);
    end
    tick();
    checks++;
    if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL receive_pulse got %b/%h want 0/a5", rx_valid, rx_data);
    end
  endtask

  task automatic test_burst;
    logic [7:0] td [13] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                            8'h05, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00};
    logic       tv [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ex [13] = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000,
                            4'b0100, 4'b0100, 4'b1111, 4'b1110, 4'b0000, 4'b0000};
    logic [7:0] got [$];
    gnt = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tx_valid = tv[i]; tx_data = td[i];
      #1;
      checks++;
      if (ctl !== ex[i]) begin
        errors++;
        $display("FAIL burst_ctl c%0d got %b want %b", i, ctl, ex[i]);
      end
      if (ex[i][3]) begin
        checks++;
        if (bus !== td[i]) begin
          errors++;
          $display("FAIL burst_bus c%0d got %h want %h", i, bus, td[i]);
        end
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL burst_acks got %0d want 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== 8'(k + 1)) begin
          errors++;
          $display("FAIL burst_order w%0d got %h want %h", k, got[k], 8'(k + 1));
        end
      end
    end
    gnt = 1'b0;
  endtask

  task automatic test_grant_loss;
    logic [7:0] td [7] = '{8'h11, 8'h11, 8'h11, 8'h12, 8'h13, 8'h13, 8'h13};
    logic       gn [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ex [7] = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b1100, 4'b0000, 4'b0100};
    int acks = 0;
    tx_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      gnt = gn[i]; tx_data = td[i];
      #1;
      checks++;
      if (ctl !== ex[i]) begin
        errors++;
        $display("FAIL gntloss_ctl c%0d got %b want %b", i, ctl, ex[i]);
      end
      if (tx_valid && tx_ready) acks++;
      tick();
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL gntloss_acks got %0d want 2", acks);
    end
    tx_valid = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    tx_valid = 1'b1; gnt = 1'b1; tx_data = 8'h99;
    strb_in = 1'b1; drv_en = 1'b1; drv_val = 8'h3C;
    tick();
    strb_in = 1'b0; drv_en = 1'b0;
    #1;
    checks++;
    if ({rx_valid, rx_data, ctl} !== {1'b1, 8'h3C, 4'b0100}) begin
      errors++;
      $display("FAIL contention_rx got %b/%h/%b want 1/3c/0100", rx_valid, rx_data, ctl);
    end
    tick();
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL contention_ta got %b want 0100", ctl);
    end
    tick();
    tx_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin
      errors++;
      $display("FAIL contention_drive got %b want 1110", ctl);
    end
    tick();
    tick();
    gnt = 1'b0;
  endtask

  task automatic test_collision;
    tx_valid = 1'b1; gnt = 1'b1; tx_data = 8'h77;
    tick();
    tick();
    strb_in = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b1111) begin
      errors++;
      $display("FAIL collision_drive got %b want 1111", ctl);
    end
    tick();
    strb_in = 1'b0; tx_valid = 1'b0;
    #1;
    checks++;
    if ({collision, rx_valid, rx_data} !== {1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL collision_pulse got %b/%b/%h want 1/0/3c", collision, rx_valid, rx_data);
    end
    tick();
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear got %b want 0", collision);
    end
    tick();
    gnt = 1'b0;
  endtask

  task automatic test_back_to_back;
    drv_en = 1'b1; strb_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_val = 8'(8'h81 + k);
      tick();
      checks++;
      if ({rx_valid, rx_data} !== {1'b1, 8'(8'h81 + k)}) begin
        errors++;
        $display("FAIL b2b_rx w%0d got %b/%h want 1/%h", k, rx_valid, rx_data, 8'(8'h81 + k));
      end
    end
    drv_en = 1'b0; strb_in = 1'b0;
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got %b want 0", rx_valid);
    end
  endtask

  task automatic test_reset_mid_burst;
    tx_valid = 1'b1; gnt = 1'b1; tx_data = 8'h44;
    tick();
    tick();
    tick();
    tx_data = 8'h45;
    #1;
    checks++;
    if (ctl !== 4'b1111) begin
      errors++;
      $display("FAIL rstmid_drive got %b want 1111", ctl);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ctl, rx_valid, collision, rx_data} !== {4'b0000, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_outputs got %b/%b/%b/%h want 0000/0/0/00", ctl, rx_valid, collision, rx_data);
    end
    checks++;
    if (dut.burst_r !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_burst got %0d want 0", dut.burst_r);
    end
    tick();
    rst = 1'b0; tx_valid = 1'b0; gnt = 1'b0;
    drv_en = 1'b1; drv_val = 8'h5A; strb_in = 1'b1;
    tick();
    drv_en = 1'b0; strb_in = 1'b0;
    #1;
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL rstmid_receive got %b/%h want 1/5a", rx_valid, rx_data);
    end
  endtask

  initial begin
    rst = 1'b1; strb_in = 1'b0; gnt = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    drv_en = 1'b0; drv_val = 8'h00;
    test_reset();
    test_receive();
    test_burst();
    test_grant_loss();
    test_contention();
    test_collision();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
